// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the FFT sequencer
// Purpose: transform size, pair count, stage-counter width and FSM state type
//          used by fft_seq_ctrl and fft_tw_addr.
package fft_pkg;

  localparam int LOG2N = 6;                // log2 of FFT length N
  localparam int P     = 1 << (LOG2N - 1); // pair slots per phase (N/2)
  localparam int SW    = 3;                // stage-counter width, 2^SW > LOG2N

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_UNLOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_tw_addr.sv
// rtl/fft_tw_addr.sv - twiddle ROM address decode for one butterfly pair
// Purpose: maps (stage k, pair counter cnt) onto the two twiddle ROM addresses.
// Ports:
//   k     in  SW      compute stage (1..LOG2N), 0 when not computing
//   cnt   in  LOG2N-1 pair counter within the stage
//   tw_a1 out LOG2N-1 twiddle address for butterfly output 0
//   tw_a2 out LOG2N-1 twiddle address for butterfly output 1
module fft_tw_addr #(
  parameter int LOG2N = fft_pkg::LOG2N,
  parameter int SW    = fft_pkg::SW
) (
  input  logic [SW-1:0]      k,
  input  logic [LOG2N-2:0]   cnt,
  output logic [LOG2N-2:0]   tw_a1,
  output logic [LOG2N-2:0]   tw_a2
);

  localparam int PW = LOG2N - 1;
  localparam logic [PW-1:0] TOP = PW'(1) << (PW - 1);

  logic          h;
  logic [SW-1:0] q;
  logic [PW-1:0] low;
  logic [PW-1:0] rev;

  assign h = cnt[PW-1];

  // Stage q = k-1 uses the low q counter bits, bit-reversed into the top of
  // the address and gated by the upper-half flag h. Output 1 additionally
  // carries h one position below those bits. The final stage uses twiddle 0.
  always_comb begin
    q     = '0;
    low   = '0;
    rev   = '0;
    tw_a1 = '0;
    tw_a2 = '0;
    if (k != '0 && k < SW'(LOG2N)) begin
      q     = k - SW'(1);
      low   = cnt & ((PW'(1) << q) - PW'(1));
      rev   = {<<{low}};
      tw_a1 = rev & {PW{h}};
      tw_a2 = tw_a1 | ({PW{h}} & (TOP >> q));
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - LOAD/COMPUTE/UNLOAD sequencer for the constant-geometry FFT
// Purpose: counter-based FSM driving memory addresses, banks, twiddle addresses,
//          input-mux select and the start/done handshake.
// Ports:
//   CK, RST          clock, synchronous active-low reset
//   ST, ABORT        start request (IDLE only), cancel current transform
//   IN_VLD / IN_RDY  input pair handshake (LOAD)
//   OUT_VLD/OUT_RDY  output pair handshake (UNLOAD)
//   BUSY, DONE       not-idle flag, one-cycle completion pulse
//   SEL_IN           write data source: 1 = input port, 0 = butterfly
//   WR_EN/WR_A/WR_BANK  memory write strobe, pair index, bank
//   RD_A/RD_BANK     memory read pair index, bank
//   TW_A1/TW_A2      twiddle ROM addresses
//   STAGE            compute stage 1..LOG2N, 0 outside COMPUTE
module fft_seq_ctrl #(
  parameter int LOG2N = fft_pkg::LOG2N,
  parameter int SW    = fft_pkg::SW
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             ST,
  input  logic             ABORT,
  input  logic             IN_VLD,
  output logic             IN_RDY,
  input  logic             OUT_RDY,
  output logic             OUT_VLD,
  output logic             BUSY,
  output logic             DONE,
  output logic             SEL_IN,
  output logic             WR_EN,
  output logic [LOG2N-2:0] WR_A,
  output logic             WR_BANK,
  output logic [LOG2N-2:0] RD_A,
  output logic             RD_BANK,
  output logic [LOG2N-2:0] TW_A1,
  output logic [LOG2N-2:0] TW_A2,
  output logic [SW-1:0]    STAGE
);

  localparam int PW = LOG2N - 1;
  localparam logic [PW-1:0] CNT_LAST  = {PW{1'b1}};
  localparam logic [SW-1:0] K_LAST    = SW'(LOG2N);
  localparam logic          UNL_BANK  = 1'(LOG2N % 2);

  import fft_pkg::*;

  state_t        state;
  logic [PW-1:0] cnt;
  logic [SW-1:0] k;
  logic          done_q;

  logic is_load, is_comp, is_unl;

  always_ff @(posedge CK) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      k      <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE && ABORT) begin
        state <= S_IDLE;
        cnt   <= '0;
        k     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (ST && !ABORT) begin
              state <= S_LOAD;
              cnt   <= '0;
            end
          end
          S_LOAD: begin
            if (IN_VLD) begin
              if (cnt == CNT_LAST) begin
                state <= S_COMPUTE;
                k     <= SW'(1);
                cnt   <= '0;
              end else begin
                cnt <= cnt + PW'(1);
              end
            end
          end
          S_COMPUTE: begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (k == K_LAST) begin
                state <= S_UNLOAD;
                k     <= '0;
              end else begin
                k <= k + SW'(1);
              end
            end else begin
              cnt <= cnt + PW'(1);
            end
          end
          S_UNLOAD: begin
            if (OUT_RDY) begin
              if (cnt == CNT_LAST) begin
                state  <= S_IDLE;
                cnt    <= '0;
                done_q <= 1'b1;
              end else begin
                cnt <= cnt + PW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign is_load = (state == S_LOAD);
  assign is_comp = (state == S_COMPUTE);
  assign is_unl  = (state == S_UNLOAD);

  assign BUSY    = (state != S_IDLE);
  assign DONE    = done_q;
  assign IN_RDY  = is_load;
  assign SEL_IN  = is_load;
  assign OUT_VLD = is_unl;
  assign WR_EN   = (is_load & IN_VLD) | is_comp;
  assign WR_A    = (is_load | is_comp) ? cnt : '0;
  // Stage k writes bank k&1 and reads the bank stage k-1 wrote, i.e. ~k[0].
  assign WR_BANK = is_comp & k[0];
  assign RD_A    = (is_comp | is_unl) ? cnt : '0;
  assign RD_BANK = (is_comp & ~k[0]) | (is_unl & UNL_BANK);
  assign STAGE   = k;

  // k is 0 outside COMPUTE, which forces both twiddle addresses to 0.
  fft_tw_addr #(
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_tw (
    .k     (k),
    .cnt   (cnt),
    .tw_a1 (TW_A1),
    .tw_a2 (TW_A2)
  );

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb/tb_fft_seq_ctrl.sv - directed self-checking bench for fft_seq_ctrl
module tb_fft_seq_ctrl;

  logic       CK = 1'b0;
  logic       RST = 1'b0;
  logic       ST = 1'b0;
  logic       ABORT = 1'b0;
  logic       IN_VLD = 1'b0;
  logic       OUT_RDY = 1'b0;
  logic       IN_RDY, OUT_VLD, BUSY, DONE, SEL_IN, WR_EN, WR_BANK, RD_BANK;
  logic [4:0] WR_A, RD_A, TW_A1, TW_A2;
  logic [2:0] STAGE;

  int n_assert = 0;
  int n_fail   = 0;

  fft_seq_ctrl dut (
    .CK      (CK),
    .RST     (RST),
    .ST      (ST),
    .ABORT   (ABORT),
    .IN_VLD  (IN_VLD),
    .IN_RDY  (IN_RDY),
    .OUT_RDY (OUT_RDY),
    .OUT_VLD (OUT_VLD),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .SEL_IN  (SEL_IN),
    .WR_EN   (WR_EN),
    .WR_A    (WR_A),
    .WR_BANK (WR_BANK),
    .RD_A    (RD_A),
    .RD_BANK (RD_BANK),
    .TW_A1   (TW_A1),
    .TW_A2   (TW_A2),
    .STAGE   (STAGE)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [31:0] pack_obs();
    return {11'b0, BUSY, IN_RDY, OUT_VLD, DONE, SEL_IN, WR_EN, WR_BANK, RD_BANK,
            STAGE, WR_A, RD_A};
  endfunction

  // Expected outputs for cycle c of an unstalled transform (c=1 is the first LOAD cycle).
  function automatic logic [31:0] exp_full(input int c);
    logic busy, inrdy, ovld, done, comp, wbank, rbank;
    int stg, wa, ra;
    busy  = (c <= 256);
    inrdy = (c <= 32);
    ovld  = (c >= 225 && c <= 256);
    done  = (c == 257);
    comp  = (c >= 33 && c <= 224);
    stg   = comp ? (c - 33) / 32 + 1 : 0;
    wbank = comp ? stg[0] : 1'b0;
    rbank = comp ? ~stg[0] : 1'b0;
    wa    = inrdy ? c - 1 : (comp ? (c - 33) % 32 : 0);
    ra    = comp ? (c - 33) % 32 : (ovld ? c - 225 : 0);
    return {11'b0, busy, inrdy, ovld, done, inrdy, inrdy | comp, wbank, rbank,
            3'(stg), 5'(wa), 5'(ra)};
  endfunction

  task automatic run_full();
    IN_VLD  = 1'b1;
    OUT_RDY = 1'b1;
    ST      = 1'b1;
    tick();
    for (int c = 1; c <= 258; c++) begin
      ST = (c == 5 || c == 100);
      #1;
      chk("full_cyc", pack_obs(), exp_full(c));
      if (c == 49)  chk("tw_k1", {TW_A1, TW_A2}, {5'h00, 5'h10});
      if (c == 116) chk("tw_k3", {TW_A1, TW_A2}, {5'h18, 5'h1C});
      if (c <= 32 || c >= 193) chk("tw_zero", {TW_A1, TW_A2}, 10'h0);
      tick();
    end
    ST = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_outs", pack_obs(), 32'h0);
    chk("reset_tw", {TW_A1, TW_A2}, 10'h0);

    // Reset mid-COMPUTE at k=3, cnt=10
    RST = 1'b1; ST = 1'b1; IN_VLD = 1'b1; OUT_RDY = 1'b1;
    tick();
    ST = 1'b0;
    repeat (106) tick();
    chk("pre_rst_stage", STAGE, 3);
    chk("pre_rst_wa", WR_A, 10);
    RST = 1'b0;
    tick();
    chk("mid_rst_outs", pack_obs(), 32'h0);
    chk("mid_rst_tw", {TW_A1, TW_A2}, 10'h0);
    RST = 1'b1;
    tick();
    chk("post_rst_busy", BUSY, 0);

    // Full unstalled transform, ST pulses while busy are ignored
    run_full();

    // LOAD with IN_VLD toggling, UNLOAD with a 5-cycle stall at cnt=7
    IN_VLD = 1'b0;
    ST = 1'b1;
    tick();
    ST = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      IN_VLD = (c % 2 == 0);
      #1;
      chk("tog_load", {IN_RDY, WR_EN, WR_A}, {1'b1, 1'(c % 2 == 0), 5'((c - 1) / 2)});
      tick();
    end
    IN_VLD = 1'b0;
    #1;
    chk("tog_comp_start", {IN_RDY, STAGE}, {1'b0, 3'd1});
    repeat (192) tick();
    for (int u = 0; u <= 36; u++) begin
      OUT_RDY = !(u >= 7 && u <= 11);
      #1;
      chk("stall_unload", {OUT_VLD, RD_BANK, RD_A},
          {1'b1, 1'b0, 5'((u < 7) ? u : ((u <= 12) ? 7 : u - 5))});
      tick();
    end
    OUT_RDY = 1'b1;
    #1;
    chk("stall_done", {DONE, BUSY}, 2'b10);
    tick();
    chk("stall_done_end", {DONE, BUSY}, 2'b00);

    // ABORT at COMPUTE k=2
    IN_VLD = 1'b1;
    ST = 1'b1;
    tick();
    ST = 1'b0;
    repeat (69) tick();
    chk("abort_pre_stage", STAGE, 2);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    #1;
    chk("abort_idle", {BUSY, DONE, STAGE}, 5'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", {BUSY, DONE}, 2'b00);
    end
    // ST together with ABORT in IDLE is refused
    ST = 1'b1; ABORT = 1'b1;
    tick();
    ST = 1'b0; ABORT = 1'b0;
    #1;
    chk("st_abort_idle", BUSY, 0);

    // Clean transform after abort
    run_full();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the 64-point, 2-samples-per-cycle, constant-geometry radix-2 FFT datapath: one ping-pong sample memory, one butterfly, one twiddle ROM.
- Runs three phases: LOAD (accept input pairs), COMPUTE (LOG2N butterfly stages, one pair per cycle), UNLOAD (stream result pairs with back-pressure).
- Drives memory read/write addresses, bank selects, twiddle ROM addresses, the input-mux select and the start/done handshake.
- Replaces hard-wired one-hot stage decoding with a counter-based FSM.

Parameters:
- LOG2N, 6, log2 of FFT length N; one pair per cycle gives P = N/2 pair slots per phase.
- SW, 3, stage-counter width; must satisfy 2^SW > LOG2N.

Ports:
- CK  in  1  clock, all state on rising edge.
- RST  in  1  reset, synchronous, active-low.
- ST  in  1  start request; sampled only in IDLE.
- ABORT  in  1  cancel current transform.
- IN_VLD  in  1  input pair present on the datapath input.
- IN_RDY  out  1  controller accepts an input pair this cycle.
- OUT_RDY  in  1  consumer accepts an output pair this cycle.
- OUT_VLD  out  1  output pair valid on memory read port.
- BUSY  out  1  high in every state other than IDLE.
- DONE  out  1  one-cycle pulse after the last output pair is accepted.
- SEL_IN  out  1  1 = memory write data comes from the input port, 0 = from the butterfly.
- WR_EN  out  1  memory write strobe; writes words {WR_A,0} and {WR_A,1}.
- WR_A  out  LOG2N-1  write pair index i.
- WR_BANK  out  1  write bank.
- RD_A  out  LOG2N-1  read pair index j; reads words j and j+P (COMPUTE), or 2j and 2j+1 (UNLOAD).
- RD_BANK  out  1  read bank.
- TW_A1  out  LOG2N-1  twiddle ROM address for butterfly output 0.
- TW_A2  out  LOG2N-1  twiddle ROM address for butterfly output 1.
- STAGE  out  SW  current compute stage k (1..LOG2N), 0 outside COMPUTE.

Behaviour:
- Registered state:
  - state ∈ {IDLE, LOAD, COMPUTE, UNLOAD}
  - cnt (LOG2N-1 bits)
  - k (SW bits)
- All other outputs are combinational decodes of the registered state; there is no added latency. The memory read is asynchronous and the write is synchronous.
- Reset (RST=0 at an edge), from any state including mid-transform: state=IDLE, cnt=0, k=0. All outputs are 0; the twiddle address outputs are 0.
- IDLE:
  - ST=1 and ABORT=0 → LOAD, cnt=0.
  - ST=1 together with ABORT=1 → remain in IDLE.
- LOAD:
  - IN_RDY=1, SEL_IN=1, WR_EN=IN_VLD, WR_A=cnt, WR_BANK=0.
  - cnt increments only when IN_VLD=1.
  - IN_VLD with cnt=P-1 → COMPUTE, k=1, cnt=0.
- COMPUTE (no stalls, exactly P cycles per stage):
  - WR_EN=1, SEL_IN=0.
  - RD_A=cnt, RD_BANK=(k-1)&1.
  - WR_A=cnt, WR_BANK=k&1.
  - cnt=P-1 with k<LOG2N → k+1, cnt=0.
  - cnt=P-1 with k=LOG2N → UNLOAD, cnt=0, k=0.
- Twiddle addresses (COMPUTE only; 0 elsewhere). Let h=cnt[LOG2N-2] and q=k-1.
  - If k=LOG2N: TW_A1=TW_A2=0.
  - Otherwise TW_A1 bit (LOG2N-2-m) = h & cnt[m] for m=0..q-1; all other bits 0.
  - TW_A2 = TW_A1 with bit (LOG2N-2-q) set to h.
- UNLOAD:
  - OUT_VLD=1, RD_A=cnt, RD_BANK=LOG2N&1, WR_EN=0.
  - cnt increments only when OUT_RDY=1.
  - OUT_RDY with cnt=P-1 → IDLE, with DONE=1 for the following cycle only.
- ABORT=1 in LOAD, COMPUTE or UNLOAD: go to IDLE next edge, cnt=0, k=0, no DONE pulse. ABORT takes priority over all other transitions.
- ST while BUSY is ignored; it is not queued.
- Counter wrap: cnt wraps P-1→0 only at the phase/stage transitions above. cnt never wraps inside a phase.
- Cycle count with no back-pressure (P=32): LOAD 32, COMPUTE LOG2N·P=192, UNLOAD 32. DONE appears 257 cycles after the first LOAD cycle.

Decomposition:
- Shared package fft_pkg holds:
  - LOG2N
  - pair-count constant P
  - state encoding (IDLE=0, LOAD=1, COMPUTE=2, UNLOAD=3)
  - stage-counter width
- Sub-module fft_tw_addr: purely combinational (k, cnt) → (TW_A1, TW_A2), so the twiddle mapping can be verified on its own.

Test Plan:
- Reset mid-COMPUTE (k=3, cnt=10), RST=0 for 1 edge → state IDLE, BUSY=0, WR_EN=0, STAGE=0, TW_A1=TW_A2=0.
- ST pulse, IN_VLD held high, OUT_RDY held high → IN_RDY high for 32 cycles, STAGE steps 1..6 every 32 cycles, OUT_VLD for 32 cycles, DONE single pulse at cycle 257, BUSY low afterwards.
- Twiddle check in k=1: cnt=0x10 → TW_A1=0, TW_A2=0x10. In k=3: cnt=0x13 → TW_A1=0x18, TW_A2=0x1C. In k=6: any cnt → both 0.
- Bank sequencing: k=1 reads bank 0, writes bank 1; k=2 reads 1, writes 0; UNLOAD reads bank 0.
- IN_VLD toggling 1/0 during LOAD → WR_EN follows IN_VLD, WR_A increments only on valid cycles, LOAD lasts 64 cycles. OUT_RDY low for 5 cycles at cnt=7 → RD_A holds 7, OUT_VLD stays 1.
- ABORT at COMPUTE k=2 → IDLE next cycle, no DONE. A new ST afterwards is accepted and runs a clean transform. ST while BUSY has no effect.
